pwr_toggle_arbiter: RTL and testbench
=====================================

Name: pwr_toggle_arbiter

Overview:
- Collects output-toggle events from up to N_REQ power-instrumented cells.
- One shared CNT_W-bit incrementer updates a per-cell toggle-count bank, one increment per cycle. The incrementer is the resource being arbitrated.
- Per-requester pending counters buffer bursts. A round-robin scheduler drains them.
- Sits beside the delayed-cell netlist and provides a synthesizable replacement for hierarchical power-counter updates.

Parameters:
- N_REQ, 4, number of event requesters.
- IDX_W, 2, index width; 2^IDX_W >= N_REQ.
- CNT_W, 16, width of each toggle-count accumulator.
- PEND_W, 3, width of each pending-event counter.

Ports:
- C  input  1  clock; all state updates on posedge C.
- R  input  1  synchronous active-high reset.
- ev  input  N_REQ  per-requester toggle-event pulse; at most one event per requester per cycle.
- clr  input  1  synchronous clear of counts, pending and overflow flags.
- rd_en  input  1  readout request.
- rd_idx  input  IDX_W  readout index.
- rd_data  output  CNT_W  registered count for rd_idx.
- rd_vld  output  1  rd_data valid, one cycle after rd_en.
- gnt_vld  output  1  an increment was performed this cycle (registered).
- gnt_idx  output  IDX_W  requester serviced (registered).
- ovf  output  N_REQ  sticky per-requester event-loss flag.
- busy  output  1  any pending counter nonzero (registered).

Behaviour:
- Reset (R=1 at posedge C):
  - All counts, pending counters, ovf, rd_data, rd_vld, gnt_vld, gnt_idx and busy go to 0.
  - Round-robin pointer goes to N_REQ-1, so requester 0 has first priority.
  - R overrides every other input. R asserted mid-drain discards all pending events without setting ovf.
- clr (R=0): same effect as R on counts, pending, ovf, busy and gnt_vld. Differences:
  - RR pointer and gnt_idx keep their values.
  - Events arriving in the clr cycle are discarded.
  - rd_en in the clr cycle returns the pre-clear value.
- Pending update, per requester i, each cycle:
  - pend_next = pend + ev[i] - (granted i this cycle).
  - Simultaneous event and grant: pend is unchanged.
  - pend at all-ones (7) with ev[i]=1 and no grant: pend stays 7 and ovf[i] is set. ovf[i] is sticky until R or clr.
- Arbitration (combinational on current pend):
  - Eligible = pend != 0.
  - Search from pointer+1 upward, wrapping modulo N_REQ.
  - The first eligible requester is granted and the pointer moves to it.
  - No eligible requester: no grant, pointer unchanged.
  - Events arriving this cycle are not eligible until the next cycle. Latency from ev pulse to gnt_vld is 2 cycles minimum.
- Increment: granted count[i] += 1, saturating at 2^CNT_W-1 (no wrap). gnt_vld/gnt_idx are registered copies of the grant, valid the cycle after the count update is committed.
- Readout:
  - rd_en at edge k gives rd_data = count[rd_idx] as held before edge k, with rd_vld=1 after edge k.
  - A grant to the same index in the same cycle is not reflected.
  - rd_idx >= N_REQ returns 0 with rd_vld=1.
  - rd_data holds its last value when rd_en=0. rd_vld is a one-cycle pulse.
- busy: registered OR-reduction of pend_next != 0.
- Throughput: one increment per cycle. Sustained aggregate event rate above 1/cycle grows pending until overflow.

Test Plan:
- Reset: R=1 for 2 cycles with ev=4'b1111 → all outputs 0, busy=0, no ovf. First grant after release goes to index 0.
- Round-robin: single-cycle ev=4'b1111 → gnt_idx 0,1,2,3 on 4 consecutive cycles, first gnt_vld 2 cycles after ev. Reading each index then gives rd_data=1. busy drops after the last grant.
- Contention/fairness: ev[0] held 1 continuously and ev[2] pulsed once → index 2 granted within 2 grants. count[0] keeps rising and ovf[0] stays 0, because event and grant on the same requester cancel.
- Overflow: ev=4'b1111 held 12 cycles, PEND_W=3 → at least one ovf bit set. Total of all counts after drain equals 48 minus lost events, and lost events are each 1 per cycle while pend was saturated.
- Saturation: CNT_W=4 and 20 pulses on ev[1] spaced 3 cycles → rd_data for idx 1 = 15, not 4.
- Clear and read collision: clr with a pending burst and rd_en same cycle → rd_data = pre-clear count. Next read returns 0, busy=0 and ovf=0. The RR pointer is preserved (next ev=4'b1111 after clr is served starting at last gnt_idx+1).

Source files
------------

// File: rtl/pwr_toggle_arbiter.sv
// ============================================================================
//  Module   : pwr_toggle_arbiter
//  Purpose  : Round-robin arbitration of per-cell toggle events onto one shared
//             saturating incrementer that updates a bank of toggle counters.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pwr_toggle_arbiter #(
    parameter int N_REQ  = 4,
    parameter int IDX_W  = 2,
    parameter int CNT_W  = 16,
    parameter int PEND_W = 3
) (
    input  logic             C,
    input  logic             R,
    input  logic [N_REQ-1:0] ev,
    input  logic             clr,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_vld,
    output logic             gnt_vld,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N_REQ-1:0] ovf,
    output logic             busy
);

    localparam logic [IDX_W:0]    c_n_req    = (IDX_W+1)'(N_REQ);
    localparam logic [IDX_W-1:0]  c_ptr_rst  = IDX_W'(N_REQ - 1);
    localparam logic [PEND_W-1:0] c_pend_one = PEND_W'(1);
    localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);

    logic [CNT_W-1:0]  r_cnt  [N_REQ];
    logic [PEND_W-1:0] r_pend [N_REQ];
    logic [IDX_W-1:0]  r_ptr;

    logic              w_gnt;
    logic [IDX_W-1:0]  w_gnt_idx;
    logic [IDX_W-1:0]  w_cand;
    logic [N_REQ-1:0]  w_hit;
    logic [N_REQ-1:0]  w_lose;
    logic [PEND_W-1:0] w_pend_nxt [N_REQ];
    logic              w_busy_nxt;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        w_gnt     = 1'b0;
        w_gnt_idx = r_ptr;
        w_cand    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = IDX_W'((int'(r_ptr) + k) % N_REQ);
            if (!w_gnt && (r_pend[w_cand] != '0)) begin
                w_gnt     = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_hit      = '0;
        w_lose     = '0;
        w_busy_nxt = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            w_hit[i]      = w_gnt && (w_gnt_idx == IDX_W'(i));
            w_pend_nxt[i] = r_pend[i];
            if (ev[i] && !w_hit[i]) begin
                if (r_pend[i] == '1)
                    w_lose[i] = 1'b1;
                else
                    w_pend_nxt[i] = r_pend[i] + c_pend_one;
            end else if (!ev[i] && w_hit[i]) begin
                w_pend_nxt[i] = r_pend[i] - c_pend_one;
            end
            w_busy_nxt = w_busy_nxt | (w_pend_nxt[i] != '0);
        end
    end

    always_ff @(posedge C) begin
        if (R) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_cnt[i]  <= '0;
                r_pend[i] <= '0;
            end
            r_ptr   <= c_ptr_rst;
            ovf     <= '0;
            busy    <= 1'b0;
            gnt_vld <= 1'b0;
            gnt_idx <= '0;
            rd_data <= '0;
            rd_vld  <= 1'b0;
        end else begin
            if (clr) begin
                for (int i = 0; i < N_REQ; i++) begin
                    r_cnt[i]  <= '0;
                    r_pend[i] <= '0;
                end
                ovf     <= '0;
                busy    <= 1'b0;
                gnt_vld <= 1'b0;
            end else begin
                for (int i = 0; i < N_REQ; i++) begin
                    r_pend[i] <= w_pend_nxt[i];
                    if (w_hit[i] && (r_cnt[i] != '1))
                        r_cnt[i] <= r_cnt[i] + c_cnt_one;
                end
                ovf     <= ovf | w_lose;
                busy    <= w_busy_nxt;
                gnt_vld <= w_gnt;
                if (w_gnt) begin
                    gnt_idx <= w_gnt_idx;
                    r_ptr   <= w_gnt_idx;
                end
            end

            // Readout samples the bank before this edge's update or clear.
            rd_vld <= rd_en;
            if (rd_en)
                rd_data <= ({1'b0, rd_idx} < c_n_req) ? r_cnt[rd_idx] : '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pwr_toggle_arbiter.sv
// ============================================================================
//  Module   : tb_pwr_toggle_arbiter
//  Purpose  : Directed vector table plus hand sequences for pwr_toggle_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pwr_toggle_arbiter;

    localparam int N_REQ  = 4;
    localparam int IDX_W  = 2;
    localparam int CNT_W  = 4;
    localparam int PEND_W = 3;

    logic             C;
    logic             R;
    logic [N_REQ-1:0] ev;
    logic             clr;
    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic [CNT_W-1:0] rd_data;
    logic             rd_vld;
    logic             gnt_vld;
    logic [IDX_W-1:0] gnt_idx;
    logic [N_REQ-1:0] ovf;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    pwr_toggle_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W),
        .PEND_W(PEND_W)
    ) dut (
        .C      (C),
        .R      (R),
        .ev     (ev),
        .clr    (clr),
        .rd_en  (rd_en),
        .rd_idx (rd_idx),
        .rd_data(rd_data),
        .rd_vld (rd_vld),
        .gnt_vld(gnt_vld),
        .gnt_idx(gnt_idx),
        .ovf    (ovf),
        .busy   (busy)
    );

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    typedef struct {
        logic             r;
        logic [N_REQ-1:0] ev;
        logic             rd_en;
        logic [IDX_W-1:0] rd_idx;
        logic             e_gv;
        logic [IDX_W-1:0] e_gi;
        logic             e_busy;
        logic [N_REQ-1:0] e_ovf;
        logic             e_rv;
        logic [CNT_W-1:0] e_rd;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(input logic r, input logic [3:0] e, input logic re,
                                input logic [1:0] ri, input logic gv, input logic [1:0] gi,
                                input logic b, input logic [3:0] o, input logic rv,
                                input logic [3:0] rd);
        vec_t v;
        v.r = r; v.ev = e; v.rd_en = re; v.rd_idx = ri;
        v.e_gv = gv; v.e_gi = gi; v.e_busy = b; v.e_ovf = o; v.e_rv = rv; v.e_rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic read_cnt(input logic [1:0] idx, input logic [3:0] exp, input string name);
        rd_en  = 1'b1;
        rd_idx = idx;
        tick();
        rd_en  = 1'b0;
        chk({name, "_vld"}, 32'(rd_vld), 32'd1);
        chk(name, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        int grants;
        bit drained;
        R = 1'b1; ev = 4'hF; clr = 1'b0; rd_en = 1'b0; rd_idx = '0;

        //              r  ev    re ri   gv gi   b  ovf   rv rd
        vecs[0]  = mk(1, 4'hF, 0, 2'd0, 0, 2'd0, 0, 4'h0, 0, 4'd0);
        vecs[1]  = mk(1, 4'hF, 0, 2'd0, 0, 2'd0, 0, 4'h0, 0, 4'd0);
        vecs[2]  = mk(0, 4'hF, 0, 2'd0, 0, 2'd0, 1, 4'h0, 0, 4'd0);
        vecs[3]  = mk(0, 4'h0, 0, 2'd0, 1, 2'd0, 1, 4'h0, 0, 4'd0);
        vecs[4]  = mk(0, 4'h0, 0, 2'd0, 1, 2'd1, 1, 4'h0, 0, 4'd0);
        vecs[5]  = mk(0, 4'h0, 0, 2'd0, 1, 2'd2, 1, 4'h0, 0, 4'd0);
        vecs[6]  = mk(0, 4'h0, 0, 2'd0, 1, 2'd3, 0, 4'h0, 0, 4'd0);
        vecs[7]  = mk(0, 4'h0, 0, 2'd0, 0, 2'd3, 0, 4'h0, 0, 4'd0);
        vecs[8]  = mk(0, 4'h0, 1, 2'd0, 0, 2'd3, 0, 4'h0, 1, 4'd1);
        vecs[9]  = mk(0, 4'h0, 1, 2'd1, 0, 2'd3, 0, 4'h0, 1, 4'd1);
        vecs[10] = mk(0, 4'h0, 1, 2'd2, 0, 2'd3, 0, 4'h0, 1, 4'd1);
        vecs[11] = mk(0, 4'h0, 1, 2'd3, 0, 2'd3, 0, 4'h0, 1, 4'd1);
        vecs[12] = mk(0, 4'h0, 0, 2'd0, 0, 2'd3, 0, 4'h0, 0, 4'd1);

        for (int v = 0; v < 13; v++) begin
            R = vecs[v].r; ev = vecs[v].ev; rd_en = vecs[v].rd_en; rd_idx = vecs[v].rd_idx;
            tick();
            chk($sformatf("v%0d_gnt_vld", v), 32'(gnt_vld), 32'(vecs[v].e_gv));
            chk($sformatf("v%0d_gnt_idx", v), 32'(gnt_idx), 32'(vecs[v].e_gi));
            chk($sformatf("v%0d_busy", v),    32'(busy),    32'(vecs[v].e_busy));
            chk($sformatf("v%0d_ovf", v),     32'(ovf),     32'(vecs[v].e_ovf));
            chk($sformatf("v%0d_rd_vld", v),  32'(rd_vld),  32'(vecs[v].e_rv));
            chk($sformatf("v%0d_rd_data", v), 32'(rd_data), 32'(vecs[v].e_rd));
        end
        rd_en = 1'b0; ev = '0;

        // Contention: ev[0] held, ev[2] pulsed once
        ev = 4'b0001; tick(); chk("cont_a_gv", 32'(gnt_vld), 32'd0);
        tick();                chk("cont_b_gi", 32'(gnt_idx), 32'd0);
        ev = 4'b0101; tick();  chk("cont_c_gi", 32'(gnt_idx), 32'd0);
        ev = 4'b0001; tick();  chk("cont_d_gi", 32'(gnt_idx), 32'd2);
        for (int e = 0; e < 6; e++) begin
            tick();
            chk($sformatf("cont_e%0d_gi", e), 32'(gnt_idx), 32'd0);
            chk($sformatf("cont_e%0d_ovf", e), 32'(ovf), 32'd0);
        end
        ev = 4'b0000;
        tick(); chk("cont_f1_gv", 32'(gnt_vld), 32'd1); chk("cont_f1_busy", 32'(busy), 32'd1);
        tick(); chk("cont_f2_gi", 32'(gnt_idx), 32'd0); chk("cont_f2_busy", 32'(busy), 32'd0);
        tick(); chk("cont_f3_gv", 32'(gnt_vld), 32'd0);
        read_cnt(2'd0, 4'd11, "cont_cnt0");
        read_cnt(2'd2, 4'd2,  "cont_cnt2");

        // Overflow: all requesters held for 12 cycles from reset
        R = 1'b1; tick(); R = 1'b0;
        chk("ovfl_rst_busy", 32'(busy), 32'd0);
        ev = 4'hF;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == 9)  chk("ovfl_t9_ovf",  32'(ovf), 32'h0);
            if (t == 10) chk("ovfl_t10_ovf", 32'(ovf), 32'hE);
            if (t == 12) chk("ovfl_t12_ovf", 32'(ovf), 32'hF);
        end
        ev = 4'h0;
        grants = 0; drained = 1'b0;
        for (int t = 0; t < 40 && !drained; t++) begin
            tick();
            if (gnt_vld) grants++;
            if (!busy) drained = 1'b1;
        end
        chk("ovfl_drained", 32'(drained), 32'd1);
        chk("ovfl_drain_grants", 32'(grants), 32'd28);
        read_cnt(2'd0, 4'd10, "ovfl_cnt0");
        read_cnt(2'd1, 4'd10, "ovfl_cnt1");
        read_cnt(2'd2, 4'd10, "ovfl_cnt2");
        read_cnt(2'd3, 4'd9,  "ovfl_cnt3");
        chk("ovfl_sticky", 32'(ovf), 32'hF);

        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr1_ovf", 32'(ovf), 32'h0);
        chk("clr1_gv", 32'(gnt_vld), 32'd0);
        read_cnt(2'd0, 4'd0, "clr1_cnt0");

        // Saturation: 20 spaced events into a 4-bit counter
        for (int p = 0; p < 20; p++) begin
            ev = 4'b0010; tick();
            ev = 4'b0000; tick(); tick();
        end
        read_cnt(2'd1, 4'd15, "sat_cnt1");
        chk("sat_ovf", 32'(ovf), 32'h0);

        // Clear colliding with a readout while a burst is pending
        ev = 4'hF; tick();
        ev = 4'h0; tick(); chk("cc_pre_gi", 32'(gnt_idx), 32'd2);
        clr = 1'b1; ev = 4'hF; rd_en = 1'b1; rd_idx = 2'd1;
        tick();
        clr = 1'b0; ev = 4'h0; rd_en = 1'b0;
        chk("cc_rd_data", 32'(rd_data), 32'd15);
        chk("cc_rd_vld",  32'(rd_vld),  32'd1);
        chk("cc_busy",    32'(busy),    32'd0);
        chk("cc_gv",      32'(gnt_vld), 32'd0);
        chk("cc_gi_kept", 32'(gnt_idx), 32'd2);
        tick(); chk("cc_idle_busy", 32'(busy), 32'd0);
        read_cnt(2'd1, 4'd0, "cc_cnt1");
        read_cnt(2'd2, 4'd0, "cc_cnt2");
        ev = 4'hF; tick(); ev = 4'h0;
        tick(); chk("cc_rr0", 32'(gnt_idx), 32'd3);
        tick(); chk("cc_rr1", 32'(gnt_idx), 32'd0);
        tick(); chk("cc_rr2", 32'(gnt_idx), 32'd1);
        tick(); chk("cc_rr3", 32'(gnt_idx), 32'd2); chk("cc_rr3_busy", 32'(busy), 32'd0);

        // Reset mid-drain discards pending work without flagging loss
        ev = 4'hF; tick(); ev = 4'h0; tick();
        R = 1'b1; tick(); R = 1'b0;
        chk("rmd_busy", 32'(busy), 32'd0);
        chk("rmd_ovf",  32'(ovf),  32'h0);
        tick(); chk("rmd_gv", 32'(gnt_vld), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
